clk_switch_seq: RTL and testbench

//   Sequencer and arbiter for the 3-source glitch-free clock switch (800M/500M/1000M).

---
 rtl/clk_switch_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 53 +++++
 rtl/clk_switch_seq.sv | 112 +++++++++++
 tb/tb_clk_switch_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_switch_pkg.sv
// Shared types, select encodings and the one-bit-per-step select walk
// for the glitch-free clock switch sequencer.
package clk_switch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStep,
    StSettle,
    StDone
  } seq_state_e;

  localparam logic [1:0] SEL_800M  = 2'b00;
  localparam logic [1:0] SEL_500M  = 2'b01;
  localparam logic [1:0] SEL_1000M = 2'b10;
  localparam logic [1:0] SEL_TRANS = 2'b11;

  // 01<->10 would flip both bits at once, so detour through 11 (1000M stays selected).
  function automatic logic [1:0] next_sel(input logic [1:0] cur, input logic [1:0] tgt);
    logic [1:0] nxt;
    if ((cur ^ tgt) == 2'b11) begin
      nxt = SEL_TRANS;
    end else begin
      nxt = tgt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer;
// the pointer moves past the winner on each advance strobe.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  logic [PtrW-1:0] ptr;
  logic [PtrW-1:0] idx_hi;
  logic [PtrW-1:0] idx_any;
  logic [PtrW-1:0] win_idx;
  logic            hit_hi;
  logic            hit_any;

  // Lowest requester at or above the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    hit_hi  = 1'b0;
    hit_any = 1'b0;
    idx_hi  = '0;
    idx_any = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        hit_any = 1'b1;
        idx_any = PtrW'(i);
        if (PtrW'(i) >= ptr) begin
          hit_hi = 1'b1;
          idx_hi = PtrW'(i);
        end
      end
    end
    win_idx = hit_hi ? idx_hi : idx_any;
    gnt     = '0;
    if (hit_any) begin
      gnt[win_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && hit_any) begin
      ptr <= (32'(win_idx) == N - 1) ? '0 : win_idx + 1'b1;
    end
  end

endmodule

// File: rtl/clk_switch_seq.sv
// Sequencer for the 3-source clock switch: arbitrates requesters, walks clk_sel
// one bit at a time with a settle window per change, then acknowledges.
module clk_switch_seq
  import clk_switch_pkg::*;
#(
  parameter int unsigned N_REQ         = 2,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter logic [1:0]  RESET_SEL     = SEL_800M
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] req_sel,
  output logic [N_REQ-1:0]   gnt,
  output logic               err,
  output logic               busy,
  output logic [1:0]         clk_sel
);

  localparam int unsigned     CntW    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(SETTLE_CYCLES - 1);

  seq_state_e       state;
  logic [CntW-1:0]  cnt;
  logic [1:0]       tgt;
  logic [N_REQ-1:0] win;
  logic             restep;
  logic [N_REQ-1:0] arb_gnt;
  logic [1:0]       win_sel;
  logic             advance;

  assign advance = (state == StIdle);

  rr_arbiter #(
    .N(N_REQ)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .advance(advance),
    .gnt    (arb_gnt)
  );

  always_comb begin
    win_sel = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (arb_gnt[i]) begin
        win_sel = req_sel[2*i +: 2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= StIdle;
      clk_sel <= RESET_SEL;
      cnt     <= '0;
      tgt     <= RESET_SEL;
      win     <= '0;
      restep  <= 1'b0;
      gnt     <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      gnt <= '0;
      err <= 1'b0;
      unique case (state)
        StIdle: begin
          if (|req) begin
            tgt  <= win_sel;
            win  <= arb_gnt;
            busy <= 1'b1;
            if (win_sel == SEL_TRANS || win_sel == clk_sel) begin
              state <= StDone;
              gnt   <= arb_gnt;
              err   <= (win_sel == SEL_TRANS);
            end else begin
              state <= StStep;
            end
          end
        end
        StStep: begin
          // A second step spends one extra cycle here before moving off the transient code.
          if (restep) begin
            restep <= 1'b0;
          end else begin
            clk_sel <= next_sel(clk_sel, tgt);
            cnt     <= CntInit;
            state   <= StSettle;
          end
        end
        StSettle: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (clk_sel != tgt) begin
            state  <= StStep;
            restep <= 1'b1;
          end else begin
            state <= StDone;
            gnt   <= win;
          end
        end
        StDone: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_switch_seq.sv
// Self-checking bench: directed scenarios plus random traffic, checked against a
// transaction-level latency/path model of the sequencer.
module tb_clk_switch_seq;

  localparam int unsigned N          = 2;
  localparam int unsigned S          = 8;
  localparam int unsigned WAIT_BOUND = N * (2 * S + 6) + 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [2*N-1:0] req_sel;
  logic [N-1:0]   gnt;
  logic           err;
  logic           busy;
  logic [1:0]     clk_sel;

  always #5 clk = ~clk;

  clk_switch_seq #(
    .N_REQ        (N),
    .SETTLE_CYCLES(S),
    .RESET_SEL    (2'b00)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .req_sel(req_sel),
    .gnt    (gnt),
    .err    (err),
    .busy   (busy),
    .clk_sel(clk_sel)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: per transaction, edge offsets (latch edge = 1) of select changes and grant.
  logic [1:0]   m_sel = 2'b00;
  logic [1:0]   m_tgt = 2'b00;
  logic [1:0]   m_mid = 2'b00;
  logic [N-1:0] m_gnt = '0;
  logic         m_err = 1'b0;
  logic         m_busy = 1'b0;
  logic         m_flag = 1'b0;
  logic         m_act = 1'b0;
  int unsigned  m_ptr = 0, m_w = 0, m_k = 0, m_g = 0, m_c1 = 0, m_c2 = 0;

  task automatic model_edge(input logic r, input logic [N-1:0] rq, input logic [2*N-1:0] rs);
    bit found;
    int unsigned idx;
    if (r) begin
      m_sel = 2'b00; m_ptr = 0; m_act = 1'b0;
      m_gnt = '0; m_err = 1'b0; m_busy = 1'b0;
      return;
    end
    m_gnt = '0;
    m_err = 1'b0;
    if (m_act) begin
      m_k++;
      if (m_k == m_c1) m_sel = m_mid;
      if (m_k == m_c2) m_sel = m_tgt;
      if (m_k == m_g + 1) m_act = 1'b0;
    end else if (rq != '0) begin
      found = 1'b0;
      for (int j = 0; j < N; j++) begin
        idx = (m_ptr + j) % N;
        if (!found && rq[idx]) begin
          found = 1'b1;
          m_w = idx;
        end
      end
      m_tgt  = rs[2*m_w +: 2];
      m_ptr  = (m_w + 1) % N;
      m_k    = 1;
      m_act  = 1'b1;
      m_c1   = 0;
      m_c2   = 0;
      m_flag = (m_tgt == 2'b11);
      if (m_tgt == 2'b11 || m_tgt == m_sel) begin
        m_g = 1;
      end else if ($countones(m_tgt ^ m_sel) == 1) begin
        m_c1 = 2; m_mid = m_tgt; m_g = S + 2;
      end else begin
        m_c1 = 2; m_mid = 2'b11; m_c2 = S + 4; m_g = 2 * S + 4;
      end
    end
    if (m_act && m_k == m_g) begin
      m_gnt = N'(1) << m_w;
      m_err = m_flag;
    end
    m_busy = m_act && (m_k <= m_g);
  endtask

  int unsigned hold_cyc[N];
  int unsigned since_chg = 0;
  bit          chg_seen  = 1'b0;

  task automatic step();
    logic           rst_s;
    logic [N-1:0]   req_s;
    logic [2*N-1:0] sel_s;
    logic [1:0]     prev;
    rst_s = rst; req_s = req; sel_s = req_sel; prev = clk_sel;
    @(posedge clk);
    #1;
    model_edge(rst_s, req_s, sel_s);
    since_chg++;
    check_eq("clk_sel", clk_sel, m_sel);
    check_eq("gnt", gnt, m_gnt);
    check_eq("err", err, m_err);
    check_eq("busy", busy, m_busy);
    check_eq("gnt_onehot0", $onehot0(gnt), 1);
    if (rst_s) begin
      chg_seen = 1'b0;
    end else if (clk_sel !== prev) begin
      check_eq("sel_hamming", $countones(clk_sel ^ prev) <= 1, 1);
      if (chg_seen) check_eq("sel_spacing", since_chg >= S + 1, 1);
      chg_seen  = 1'b1;
      since_chg = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (req[i]) hold_cyc[i]++;
      if (gnt[i]) begin
        check_eq("grant_wait", hold_cyc[i] <= WAIT_BOUND, 1);
        req[i]      = 1'b0;
        hold_cyc[i] = 0;
      end
    end
  endtask

  task automatic run_until_idle();
    for (int c = 0; c < 400; c++) begin
      if (req == '0 && !busy) break;
      step();
    end
    check_eq("idle_reached", 32'(busy || req != '0), 0);
  endtask

  task automatic issue(input int i, input logic [1:0] sel);
    req_sel[2*i +: 2] = sel;
    req[i]            = 1'b1;
    hold_cyc[i]       = 0;
  endtask

  initial begin
    bit reissued;
    rst = 1'b1; req = '0; req_sel = '0;
    for (int i = 0; i < N; i++) hold_cyc[i] = 0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // One-bit change 00->01, then two-bit change 01->11->10.
    issue(0, 2'b01);
    run_until_idle();
    issue(0, 2'b10);
    run_until_idle();

    // Simultaneous requests; requester 0 re-asserts straight after its grant.
    issue(0, 2'b10);
    issue(1, 2'b00);
    reissued = 1'b0;
    for (int c = 0; c < 400 && (req != '0 || busy); c++) begin
      step();
      if (!reissued && !req[0]) begin
        issue(0, 2'b01);
        reissued = 1'b1;
      end
    end
    check_eq("rr_pass_done", 32'(busy || req != '0), 0);

    // Illegal target and same-code target.
    issue(0, 2'b11);
    run_until_idle();
    issue(1, m_sel);
    run_until_idle();

    // Reset in the middle of a two-bit walk, then a fresh request.
    issue(0, (m_sel == 2'b01) ? 2'b10 : 2'b01);
    repeat (7) step();
    rst = 1'b1;
    req = '0;
    step();
    check_eq("rst_sel", clk_sel, 2'b00);
    check_eq("rst_busy", busy, 0);
    rst = 1'b0;
    step();
    issue(1, 2'b10);
    run_until_idle();

    // Random traffic.
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 5) == 0) issue(i, 2'($urandom_range(0, 3)));
      end
      step();
    end
    run_until_idle();
    check_eq("all_granted", req, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
